scan_seq_ctrl: RTL and testbench

- Start/done sequencer for a raster scan over a W x H frame, with a per-pixel tap loop of programmable length.
- Internally it chains three counters: a tap down-counter reloaded from a captured value, a column counter mod W and a row counter mod H.
- For each scan beat it issues a valid strobe carrying {row, col, tap} to the downstream datapath.
- It sits between the top-level controller (start/abort/done) and the datapath/output buffer, and honours the buffer's full back-pressure.

---
 rtl/scan_seq_ctrl.sv | 108 ++++++++++
 tb/tb_scan_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq_ctrl.sv
// Raster-scan sequencer: walks {row, col, tap} over a W x H frame with a
// programmable per-pixel tap loop, stalling whenever the downstream buffer is full.
module scan_seq_ctrl #(
  parameter  int W  = 16,
  parameter  int H  = 16,
  parameter  int TB = 4,
  localparam int CW = $clog2(W),
  localparam int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [TB-1:0] taps_in,
  input  logic          out_full,
  output logic          valid,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [TB-1:0] tap,
  output logic          last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [TB-1:0] r_taps;
  logic [TB-1:0] r_tap;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  logic          w_valid;
  logic          w_tap_end;
  logic          w_col_end;
  logic          w_row_end;
  logic [TB-1:0] w_taps_cap;

  assign w_valid    = (r_state == S_RUN) && !out_full;
  assign w_tap_end  = (r_tap == '0);
  assign w_col_end  = (r_col == CW'(W - 1));
  assign w_row_end  = (r_row == RW'(H - 1));
  // A zero tap request still runs one tap per pixel, so taps_reg-1 never underflows.
  assign w_taps_cap = (taps_in == '0) ? TB'(1) : taps_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_taps  <= '0;
      r_tap   <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_taps  <= w_taps_cap;
            r_tap   <= w_taps_cap - 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Odometer advance: tap is the fastest digit, row the slowest.
          if (w_valid) begin
            if (!w_tap_end) begin
              r_tap <= r_tap - 1'b1;
            end else begin
              r_tap <= r_taps - 1'b1;
              if (!w_col_end) begin
                r_col <= r_col + 1'b1;
              end else begin
                r_col <= '0;
                if (!w_row_end) begin
                  r_row <= r_row + 1'b1;
                end else begin
                  r_row   <= '0;
                  r_state <= S_DONE;
                end
              end
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid = w_valid;
  assign last  = w_valid && w_tap_end && w_col_end && w_row_end;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign row   = r_row;
  assign col   = r_col;
  assign tap   = r_tap;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: a beat-index model of the frame, compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_scan_seq_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int TB = 4;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_full = 1'b0;
  logic [TB-1:0] taps_in = '0;
  logic          valid, last, busy, done;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [TB-1:0] tap;

  scan_seq_ctrl #(.W(W), .H(H), .TB(TB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .taps_in(taps_in),
    .out_full(out_full), .valid(valid), .row(row), .col(col), .tap(tap),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: 0=idle, 1=scanning (m_idx = index of the pending beat), 2=done pulse.
  int m_st = 0, m_idx = 0, m_taps = 0, m_it = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_idx = 0; m_taps = 0; m_it = 0;
    end else if (abort) begin
      m_st = 0; m_idx = 0; m_it = 0;
    end else if (m_st == 0) begin
      if (start) begin
        m_taps = (taps_in == 0) ? 1 : int'(taps_in);
        m_idx  = 0;
        m_st   = 1;
      end
    end else if (m_st == 1) begin
      if (!out_full) begin
        if (m_idx == W * H * m_taps - 1) begin
          m_st = 2; m_idx = 0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else begin
      m_st = 0;
      m_it = m_taps - 1;
    end
  end

  typedef struct {int cyc; int r; int c; int t; bit l;} beat_t;
  beat_t blog[$];
  int cyc = 0, n_done = 0, done_cyc = 0, sum_tap = 0;
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic compare();
    int er, ec, et, idx;
    bit ev, el, eb, ed;
    cyc++;
    er = 0; ec = 0; et = m_it; ev = 0; el = 0;
    eb = (m_st != 0);
    ed = (m_st == 2);
    if (m_st != 0) begin
      idx = (m_st == 1) ? m_idx : 0;
      er  = idx / (W * m_taps);
      ec  = (idx / m_taps) % W;
      et  = m_taps - 1 - (idx % m_taps);
    end
    if (m_st == 1) begin
      ev = !out_full;
      el = ev && (m_idx == W * H * m_taps - 1);
    end
    chk($sformatf("cycle%0d {v,l,b,d,row,col,tap}", cyc),
        {valid, last, busy, done, 4'(row), 4'(col), 4'(tap)},
        {ev, el, eb, ed, 4'(er), 4'(ec), 4'(et)});
    if (valid === 1'b1) begin
      blog.push_back('{cyc, int'(row), int'(col), int'(tap), last});
      sum_tap += int'(tap);
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [TB-1:0] t);
    taps_in = t;
    start   = 1'b1;
    step();
    start   = 1'b0;
    taps_in = TB'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input int d0, input int limit, input string nm);
    int k = 0;
    while (n_done == d0 && k < limit) begin
      step();
      k++;
    end
    chk(nm, 32'(n_done != d0), 32'd1);
  endtask

  task automatic wait_beats(input int b0, input int n, input int limit, input string nm);
    int k = 0;
    while (blog.size() - b0 < n && k < limit) begin
      step();
      k++;
    end
    chk(nm, 32'(blog.size() - b0), 32'(n));
  endtask

  // Packs a logged beat as 0xLRCT (last, row, col, tap); 0xFFFF if absent.
  function automatic logic [31:0] tup(input int i);
    if (i < 0 || i >= blog.size()) return 32'hFFFF;
    return 32'((blog[i].l ? 4096 : 0) + blog[i].r * 256 + blog[i].c * 16 + blog[i].t);
  endfunction

  function automatic int count_last(input int from);
    int n = 0;
    for (int i = from; i < blog.size(); i++) if (blog[i].l) n++;
    return n;
  endfunction

  function automatic int beat_cyc(input int i);
    if (i < 0 || i >= blog.size()) return -1;
    return blog[i].cyc;
  endfunction

  initial begin
    int b0, d0, s0, c0, dfirst;

    rst = 1'b1;
    step();
    step();
    chk("reset_outputs", {valid, last, busy, done, row, col, tap}, 32'd0);
    rst = 1'b0;
    step();
    step();

    // Basic frame, taps=2
    b0 = blog.size(); d0 = n_done; s0 = sum_tap; c0 = cyc;
    start_frame(4'd2);
    wait_done(d0, 40, "basic_done_seen");
    step(); step();
    chk("basic_beats", 32'(blog.size() - b0), 32'd24);
    chk("basic_first_cycle", 32'(beat_cyc(b0)), 32'(c0 + 2));
    chk("basic_consecutive", 32'(beat_cyc(b0 + 23) - beat_cyc(b0)), 32'd23);
    chk("basic_beat1", tup(b0), 32'h001);
    chk("basic_beat2", tup(b0 + 1), 32'h000);
    chk("basic_beat3", tup(b0 + 2), 32'h011);
    chk("basic_final_beat", tup(b0 + 23), 32'h1230);
    chk("basic_last_once", 32'(count_last(b0)), 32'd1);
    chk("basic_done_after_last", 32'(done_cyc), 32'(beat_cyc(b0 + 23) + 1));
    chk("basic_tap_sum", 32'(sum_tap - s0), 32'd12);

    // Back-pressure: full in cycles 5..7 and at the 24th beat
    b0 = blog.size(); d0 = n_done;
    start_frame(4'd2);
    for (int j = 1; j <= 60 && n_done == d0; j++) begin
      out_full = ((j >= 5 && j <= 7) || j == 27);
      step();
    end
    out_full = 1'b0;
    chk("bp_done_seen", 32'(n_done - d0), 32'd1);
    chk("bp_beats", 32'(blog.size() - b0), 32'd24);
    chk("bp_last_once", 32'(count_last(b0)), 32'd1);
    chk("bp_held_beat5", tup(b0 + 4), 32'h021);
    chk("bp_beat5_delay", 32'(beat_cyc(b0 + 4) - beat_cyc(b0)), 32'd7);
    chk("bp_final_delay", 32'(beat_cyc(b0 + 23) - beat_cyc(b0)), 32'd27);
    step(); step();

    // taps_in=0 with start and out_full together
    b0 = blog.size(); d0 = n_done; s0 = sum_tap; c0 = cyc;
    out_full = 1'b1;
    start_frame(4'd0);
    step(); step();
    out_full = 1'b0;
    wait_done(d0, 40, "taps0_done_seen");
    chk("taps0_beats", 32'(blog.size() - b0), 32'd12);
    chk("taps0_tap_sum", 32'(sum_tap - s0), 32'd0);
    chk("taps0_first_cycle", 32'(beat_cyc(b0)), 32'(c0 + 4));
    step(); step();

    // taps_in=15
    b0 = blog.size(); d0 = n_done; s0 = sum_tap;
    start_frame(4'd15);
    wait_done(d0, 250, "taps15_done_seen");
    chk("taps15_beats", 32'(blog.size() - b0), 32'd180);
    chk("taps15_tap_sum", 32'(sum_tap - s0), 32'd1260);
    chk("taps15_first", tup(b0), 32'h00E);
    chk("taps15_final", tup(b0 + 179), 32'h1230);
    step(); step();

    // Abort while beat 10 is presented
    b0 = blog.size(); d0 = n_done;
    start_frame(4'd2);
    wait_beats(b0, 9, 40, "abort_reach_beat9");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outputs", {valid, last, busy, done, row, col, tap}, 32'd0);
    repeat (5) step();
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    chk("abort_beats", 32'(blog.size() - b0), 32'd10);
    b0 = blog.size();
    start_frame(4'd2);
    wait_done(d0, 40, "after_abort_done_seen");
    chk("after_abort_beats", 32'(blog.size() - b0), 32'd24);
    step(); step();

    // start held through RUN and DONE; it relaunches only once sampled in IDLE
    b0 = blog.size(); d0 = n_done;
    taps_in = 4'd2;
    start   = 1'b1;
    step();
    wait_done(d0, 40, "held_done_seen");
    dfirst = done_cyc;
    step();
    start = 1'b0;
    wait_done(d0 + 1, 40, "held_second_done_seen");
    repeat (10) step();
    chk("held_beats", 32'(blog.size() - b0), 32'd48);
    chk("held_done_count", 32'(n_done - d0), 32'd2);
    chk("held_restart_cycle", 32'(beat_cyc(b0 + 24)), 32'(dfirst + 2));

    // Asynchronous reset mid-frame
    b0 = blog.size(); d0 = n_done;
    start_frame(4'd2);
    wait_beats(b0, 7, 40, "rst_reach_beat7");
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", {valid, last, busy, done, row, col, tap}, 32'd0);
    #3 rst = 1'b0;
    repeat (5) step();
    chk("rst_idle_hold", {valid, busy, done, row, col, tap}, 32'd0);
    chk("rst_no_done", 32'(n_done - d0), 32'd0);
    b0 = blog.size();
    start_frame(4'd1);
    wait_done(d0, 40, "rst_restart_done_seen");
    chk("rst_restart_beats", 32'(blog.size() - b0), 32'd12);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
